// File: rtl/regb_fifo_pkg.sv
// Shared definitions for the register-based FIFO chain and its write arbiter:
// arbiter state encoding, a clog2 helper and default entry geometry.
package regb_fifo_pkg;

  localparam int unsigned DefWidth = 4;
  localparam int unsigned DefDepth = 8;

  typedef enum logic [0:0] {
    StArb,
    StLock
  } arb_state_e;

  // Never returns 0, so a 1-wide index still gets one bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) begin
      result = result + 1;
    end
    if (result == 0) begin
      result = 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/regb_rr_pick.sv
// Rotating-priority picker: first set bit of req at or above ptr, wrapping,
// returned as both a one-hot vector and an index.
module regb_rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  int unsigned pos;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    pos    = 0;
    for (int k = 0; k < int'(N); k++) begin
      pos = (int'(ptr) + k) % N;
      if (!any && req[pos]) begin
        any         = 1'b1;
        onehot[pos] = 1'b1;
        idx         = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/regb_fifo_wr_arbiter.sv
// Round-robin write arbiter feeding one register-based FIFO chain from N requesters.
// Define REGB_ARB_BURST_EN to hold the grant on one requester until its req_last beat.
module regb_fifo_wr_arbiter
  import regb_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned N     = 4,
  parameter int unsigned DEPTH = DefDepth,
  localparam int unsigned OW   = clog2(DEPTH + 1),
  localparam int unsigned IW   = clog2(N)
) (
  input  logic               clk,
  input  logic               res,
  input  logic [N-1:0]       req_valid,
  input  logic [N-1:0]       req_last,
  input  logic [N*WIDTH-1:0] req_data,
  output logic [N-1:0]       req_ready,
  output logic [WIDTH-1:0]   fifo_si,
  output logic               fifo_shift_in,
  input  logic               fifo_shift_out,
  output logic [OW-1:0]      occupancy,
  output logic [IW-1:0]      grant_id,
  output logic               err_underflow
);

  localparam logic [OW-1:0] DepthVal = OW'(DEPTH);
  localparam logic [IW-1:0] LastIdx  = IW'(N - 1);

  arb_state_e       state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [OW-1:0]    occ_q, occ_d;
  logic [WIDTH-1:0] si_q;
  logic             shift_in_q;
  logic [IW-1:0]    grant_q;
  logic             err_q;

  logic [N-1:0]     eligible;
  logic [N-1:0]     pick_onehot;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic             has_room;
  logic             accept;
  logic             pop_ok;
  logic [IW-1:0]    next_idx;

  // In LOCK only the burst owner is visible to the picker.
  always_comb begin
    eligible = req_valid;
    if (state_q == StLock) begin
      eligible = req_valid & (N'(1) << owner_q);
    end
  end

  regb_rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req    (eligible),
    .ptr    (ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // A pop in the same cycle does not free a slot early.
  assign has_room  = (occ_q < DepthVal);
  assign accept    = pick_any & has_room & ~res;
  assign req_ready = accept ? pick_onehot : '0;
  assign pop_ok    = fifo_shift_out & (occ_q != '0);
  assign next_idx  = (pick_idx == LastIdx) ? '0 : pick_idx + 1'b1;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = accept ? next_idx : ptr_q;
`ifdef REGB_ARB_BURST_EN
    if (accept) begin
      if (req_last[pick_idx]) begin
        state_d = StArb;
      end else begin
        state_d = StLock;
        owner_d = pick_idx;
      end
    end
`else
    state_d = StArb;
`endif
  end

`ifndef REGB_ARB_BURST_EN
  logic unused_last;
  assign unused_last = ^req_last;
`endif

  always_comb begin
    occ_d = occ_q;
    unique case ({accept, pop_ok})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q    <= StArb;
      ptr_q      <= '0;
      owner_q    <= '0;
      occ_q      <= '0;
      si_q       <= '0;
      shift_in_q <= 1'b0;
      grant_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      occ_q      <= occ_d;
      shift_in_q <= accept;
      if (accept) begin
        si_q    <= req_data[pick_idx*WIDTH +: WIDTH];
        grant_q <= pick_idx;
      end
      if (fifo_shift_out && (occ_q == '0)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign fifo_si       = si_q;
  assign fifo_shift_in = shift_in_q;
  assign occupancy     = occ_q;
  assign grant_id      = grant_q;
  assign err_underflow = err_q;

endmodule
